// File: rtl/inert_spi_slave.sv
// SPI responder standing in for the inertial sensor: 16-bit packets, small register file, data-ready INT.
// Optional INERT_OVR_EN adds the ovr output and the status register at 0x1E.
module inert_spi_slave #(
   parameter logic [15:0] ODR_PERIOD = 16'd2000,
   parameter logic [7:0]  WHO_AM_I   = 8'h6A
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        SS_n,
   input  logic        SCLK,
   input  logic        MOSI,
   output logic        MISO,
   output logic        INT,
   input  logic [15:0] ptch_rt_in,
   input  logic [15:0] roll_rt_in,
   input  logic [15:0] yaw_rt_in,
   input  logic [15:0] ax_in,
   input  logic [15:0] ay_in,
`ifdef INERT_OVR_EN
   output logic        ovr,
`endif
   output logic        cfg_done
);

   logic        ss_ff1, ss_ff2, ss_prev;
   logic        sclk_ff1, sclk_ff2, sclk_prev;
   logic        mosi_ff1, mosi_ff2;
   logic        ss_fall, ss_rise, sclk_rise, sclk_fall;

   logic [15:0] rx_shft, rx_next;
   logic [15:0] tx_shft;
   logic [4:0]  bit_cnt;

   logic [7:0]  int_en, accl_cfg, gyro_cfg, ctrl;
   logic        wr_accl, wr_gyro, wr_ctrl;
   logic [15:0] snap_ptch, snap_roll, snap_yaw, snap_ax, snap_ay;
   logic [7:0]  rd_byte;

   logic [15:0] odr_cnt;
   logic        sample_pend;
   logic        int_q;
   logic        commit, clr_int, wr_en, odr_run, odr_wrap;

   // Double-flop synchronisers; the third stage gives edge detection on synced copies.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ss_ff1    <= 1'b1;
         ss_ff2    <= 1'b1;
         ss_prev   <= 1'b1;
         sclk_ff1  <= 1'b0;
         sclk_ff2  <= 1'b0;
         sclk_prev <= 1'b0;
         mosi_ff1  <= 1'b0;
         mosi_ff2  <= 1'b0;
      end else begin
         ss_ff1    <= SS_n;
         ss_ff2    <= ss_ff1;
         ss_prev   <= ss_ff2;
         sclk_ff1  <= SCLK;
         sclk_ff2  <= sclk_ff1;
         sclk_prev <= sclk_ff2;
         mosi_ff1  <= MOSI;
         mosi_ff2  <= mosi_ff1;
      end
   end

   assign ss_fall   = ss_prev & ~ss_ff2;
   assign ss_rise   = ~ss_prev & ss_ff2;
   assign sclk_rise = sclk_ff2 & ~sclk_prev & ~ss_ff2;
   assign sclk_fall = ~sclk_ff2 & sclk_prev & ~ss_ff2;
   assign rx_next   = {rx_shft[14:0], mosi_ff2};

   // The 8th rise completes the command byte; a read of 0x22 acknowledges the interrupt.
   assign clr_int  = sclk_rise && (bit_cnt == 5'd7) && (rx_next[7:0] == 8'hA2);
   assign commit   = sample_pend & ss_ff2;
   assign wr_en    = ss_rise && (bit_cnt == 5'd16) && !rx_shft[15];
   assign odr_run  = int_en[1] & cfg_done;
   assign odr_wrap = odr_run && (odr_cnt == ODR_PERIOD - 16'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_shft <= 16'h0000;
         bit_cnt <= 5'd0;
      end else begin
         if (sclk_rise) rx_shft <= rx_next;
         if (ss_fall)
            bit_cnt <= 5'd0;
         else if (sclk_rise && (bit_cnt != 5'd31))
            bit_cnt <= bit_cnt + 5'd1;
      end
   end

   always_comb begin
      rd_byte = 8'h00;
      case (rx_shft[6:0])
         7'h0D: rd_byte = int_en;
         7'h0F: rd_byte = WHO_AM_I;
         7'h10: rd_byte = accl_cfg;
         7'h11: rd_byte = gyro_cfg;
         7'h14: rd_byte = ctrl;
`ifdef INERT_OVR_EN
         7'h1E: rd_byte = {6'b000000, ovr, int_q};
`endif
         7'h22: rd_byte = snap_ptch[7:0];
         7'h23: rd_byte = snap_ptch[15:8];
         7'h24: rd_byte = snap_roll[7:0];
         7'h25: rd_byte = snap_roll[15:8];
         7'h26: rd_byte = snap_yaw[7:0];
         7'h27: rd_byte = snap_yaw[15:8];
         7'h28: rd_byte = snap_ax[7:0];
         7'h29: rd_byte = snap_ax[15:8];
         7'h2A: rd_byte = snap_ay[7:0];
         7'h2B: rd_byte = snap_ay[15:8];
         default: rd_byte = 8'h00;
      endcase
   end

   // Reply byte is loaded at the fall after the command byte so it leads bit 8 of the frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         tx_shft <= 16'h0000;
      else if (ss_fall)
         tx_shft <= 16'h0000;
      else if (sclk_fall) begin
         if ((bit_cnt == 5'd8) && rx_shft[7])
            tx_shft <= {rd_byte, 8'h00};
         else
            tx_shft <= {tx_shft[14:0], 1'b0};
      end
   end

   assign MISO = tx_shft[15];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         int_en   <= 8'h00;
         accl_cfg <= 8'h00;
         gyro_cfg <= 8'h00;
         ctrl     <= 8'h00;
         wr_accl  <= 1'b0;
         wr_gyro  <= 1'b0;
         wr_ctrl  <= 1'b0;
      end else if (wr_en) begin
         case (rx_shft[14:8])
            7'h0D: int_en <= rx_shft[7:0];
            7'h10: begin accl_cfg <= rx_shft[7:0]; wr_accl <= 1'b1; end
            7'h11: begin gyro_cfg <= rx_shft[7:0]; wr_gyro <= 1'b1; end
            7'h14: begin ctrl     <= rx_shft[7:0]; wr_ctrl <= 1'b1; end
            default: ;
         endcase
      end
   end

   assign cfg_done = wr_accl & wr_gyro & wr_ctrl;

   // A wrap that lands on a commit cycle re-arms sample_pend, so it is assigned last.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         odr_cnt     <= 16'h0000;
         sample_pend <= 1'b0;
      end else if (!odr_run) begin
         odr_cnt <= 16'h0000;
         if (!int_en[1]) sample_pend <= 1'b0;
      end else begin
         if (commit) sample_pend <= 1'b0;
         if (odr_wrap) begin
            odr_cnt     <= 16'h0000;
            sample_pend <= 1'b1;
         end else begin
            odr_cnt <= odr_cnt + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_ptch <= 16'h0000;
         snap_roll <= 16'h0000;
         snap_yaw  <= 16'h0000;
         snap_ax   <= 16'h0000;
         snap_ay   <= 16'h0000;
         int_q     <= 1'b0;
      end else begin
         if (commit) begin
            snap_ptch <= ptch_rt_in;
            snap_roll <= roll_rt_in;
            snap_yaw  <= yaw_rt_in;
            snap_ax   <= ax_in;
            snap_ay   <= ay_in;
            int_q     <= 1'b1;
         end else if (clr_int) begin
            int_q <= 1'b0;
         end
      end
   end

   assign INT = int_q;

`ifdef INERT_OVR_EN
   // Overrun: a fresh sample replaced one the host never acknowledged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovr <= 1'b0;
      else if (commit && int_q)
         ovr <= 1'b1;
      else if (clr_int)
         ovr <= 1'b0;
   end
`endif

endmodule

// File: doc/inert_spi_slave.md
Name: inert_spi_slave

Overview:
- Synthesizable SPI responder modelling the inertial sensor at the far end of the 16-bit SPI link.
- Decodes 16-bit write/read packets and holds a small register file.
- Generates the data-ready INT at a programmable rate and returns snapshotted pitch/roll/yaw rates and ax/ay accelerations byte-wise.
- Used in the full-chip bench and on an FPGA loopback board in place of the physical sensor.

Parameters:
- ODR_PERIOD, 16'd2000, clk cycles between data-ready events once interrupts are enabled.
- WHO_AM_I, 8'h6A, read-only identification value at address 0x0F.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- SS_n  in  1  SPI slave select, active low
- SCLK  in  1  SPI clock (mode 0, idle low)
- MOSI  in  1  SPI data from master
- MISO  out  1  SPI data to master
- INT  out  1  data-ready interrupt, active high
- ptch_rt_in, roll_rt_in, yaw_rt_in  in  16 each  live rate samples
- ax_in, ay_in  in  16 each  live acceleration samples
- cfg_done  out  1  high once regs 0x10, 0x11 and 0x14 have each been written at least once

Behaviour:
- Reset and clocking: rst_n is asynchronous, active-low; clock is clk.
- Reset values: MISO=0, INT=0, cfg_done=0, all registers and snapshot = 0x00.
- Input sync: SS_n, SCLK and MOSI are double-flopped into clk; SS_n flops reset to 1.
  - SCLK rise/fall are detected from the synced copies. Edges count only while synced SS_n=0.
- Packet format: 16 bits, MSB first.
  - bit15=1 read, 0 write; bits[14:8] address; bits[7:0] write data (don't-care on reads).
- Receive: MOSI is sampled into rx_shft on each SCLK rise. bit_cnt (5b) increments per rise and clears on SS_n fall.
- Transmit: tx_shft cleared on SS_n fall; MISO = tx_shft[15]; tx_shft shifts left on each SCLK fall.
  - Exception: at the fall following the 8th rise, if rx bit7 (the R/W bit) = 1, tx_shft loads {reg[addr], 8'h00} instead of shifting.
  - Master therefore captures the register byte in rd_data[7:0]. Upper byte of any reply is 0x00.
- Transaction end (SS_n rise):
  - bit_cnt==16 and write: reg[addr] <= data byte.
  - bit_cnt!=16: packet discarded, no write.
  - Writes to read-only or unmapped addresses are ignored.
- Register map:
  - 0x0D INT_EN (bit1 enables data-ready)
  - 0x0F WHO_AM_I (RO)
  - 0x10 ACCL cfg, 0x11 GYRO cfg, 0x14 CTRL
  - 0x22/0x23 ptch L/H, 0x24/0x25 roll L/H, 0x26/0x27 yaw L/H, 0x28/0x29 ax L/H, 0x2A/0x2B ay L/H (RO snapshot)
  - Unmapped reads return 0x00.
- ODR counter:
  - Runs only while INT_EN[1]=1 and cfg_done=1; held at 0 otherwise.
  - At ODR_PERIOD-1 it wraps to 0 and raises sample_pend.
- Sample commit: when sample_pend=1 and synced SS_n=1, in one cycle:
  - all five inputs are copied into the snapshot;
  - INT <= 1; sample_pend <= 0.
  - A sample is never committed mid-transaction, so bytes read within one packet are coherent.
- INT clear: at the 8th rise of a read to 0x22. If a commit and a clear coincide, the commit wins.
- Clearing INT_EN[1]: counter resets; INT unaffected; sample_pend cleared.
- SS_n rising early (abort): bit_cnt and tx_shft reset on the next SS_n fall; no state corruption.
- Latency: INT rises 1 clk after commit. MISO first data bit is valid within 3 clk of the 8th SCLK fall, so SCLK must be ≥8 clk per period.

Optional Feature:
- Macro INERT_OVR_EN.
- With it: adds output ovr (1b, reset 0). ovr is set when a commit occurs while INT is already 1 (sample never read). It is cleared by a read of 0x22. Status reg 0x1E returns {6'b0, ovr, INT}.
- Without it: no ovr port; 0x1E reads 0x00.

Test Plan:
- Reset, then read 0x0F (cmd 16'h8F00) -> rd_data[7:0]=0x6A, upper byte 0x00; INT=0, cfg_done=0.
- Write 16'h1062, 16'h1162, 16'h1460 -> cfg_done=1. Read 0x10 -> 0x62. Write 16'h2255 -> read 0x22 still 0x00.
- Write 16'h0D02 with ptch_rt_in=16'h1234 -> INT rises ODR_PERIOD(±2) clk later. Reads of 0xA2/0xA3 return 0x34/0x12; INT falls at the 8th SCLK of the 0xA2 read.
- Hold SS_n low across a counter wrap while inputs change -> commit delayed until SS_n high. The snapshot equals the input values at that cycle, and the read in progress returns old data.
- Abort write 16'h0D00 after 10 bits -> INT_EN unchanged (0x02); the next full packet decodes correctly.
- With INERT_OVR_EN: let two ODR periods pass without reading -> ovr=1 and 0x1E reads 0x03. Reading 0x22 clears ovr and INT (0x1E = 0x00).
